// File: rtl/rom_addr_seq.sv
// ROM address sequencer: steps addr on each rising edge of the divided tick_in.
// Optional ping-pong playback via `define ADDR_SEQ_BOUNCE_EN (adds bounce_en port).
module rom_addr_seq #(
    parameter int ADDR_W   = 8,
    parameter int ADDR_MIN = 0,
    parameter int ADDR_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
`ifdef ADDR_SEQ_BOUNCE_EN
    input  logic              bounce_en,
`endif
    output logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic              step,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    localparam logic [ADDR_W-1:0] A_MIN = ADDR_W'(ADDR_MIN);
    localparam logic [ADDR_W-1:0] A_MAX = ADDR_W'(ADDR_MAX);

    state_t state;
    logic   tick_d;
    logic   tick_edge;
    logic   dir_down;
    logic   bounce_on;

    assign tick_edge = tick_in & ~tick_d;

`ifdef ADDR_SEQ_BOUNCE_EN
    assign bounce_on = bounce_en;
`else
    assign bounce_on = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= A_MIN;
            valid    <= 1'b0;
            step     <= 1'b0;
            done     <= 1'b0;
            tick_d   <= 1'b0;
            dir_down <= 1'b0;
        end else begin
            tick_d <= tick_in;
            step   <= 1'b0;
            done   <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                addr     <= A_MIN;
                valid    <= 1'b0;
                dir_down <= 1'b0;
            end else if (start) begin
                // a coincident edge is swallowed: playback begins at A_MIN without a step
                state    <= RUN;
                addr     <= A_MIN;
                valid    <= 1'b1;
                dir_down <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    PAUSE: begin
                        if (!pause)
                            state <= RUN;
                    end
                    RUN: begin
                        if (pause) begin
                            state <= PAUSE;
                        end else if (tick_edge) begin
                            if (!dir_down) begin
                                if (addr != A_MAX) begin
                                    addr <= addr + 1'b1;
                                    step <= 1'b1;
                                end else if (bounce_on) begin
                                    dir_down <= 1'b1;
                                    addr     <= A_MAX - 1'b1;
                                    step     <= 1'b1;
                                end else if (loop_en) begin
                                    addr <= A_MIN;
                                    step <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                    valid <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                if (addr != A_MIN) begin
                                    addr <= addr - 1'b1;
                                    step <= 1'b1;
                                end else if (loop_en) begin
                                    dir_down <= 1'b0;
                                    addr     <= A_MIN + 1'b1;
                                    step     <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                    valid <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_addr_seq.sv
// Directed self-checking bench for rom_addr_seq (window 2..5, tick period 6 clk).
module tb_rom_addr_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       loop_en = 1'b0;
`ifdef ADDR_SEQ_BOUNCE_EN
    logic       bounce_en = 1'b0;
`endif
    logic [3:0] addr;
    logic       valid;
    logic       step;
    logic       done;

    int errors = 0;
    int checks = 0;

    rom_addr_seq #(.ADDR_W(4), .ADDR_MIN(2), .ADDR_MAX(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .loop_en (loop_en),
`ifdef ADDR_SEQ_BOUNCE_EN
        .bounce_en (bounce_en),
`endif
        .addr    (addr),
        .valid   (valid),
        .step    (step),
        .done    (done)
    );

    always #5 clk = ~clk;

    // One tick_in period (3 high, 3 low). smp1 = {addr,step,done,valid} one clk after the
    // rise, smp2 = {step,done} the cycle after that.
    task automatic tick_period(output logic [6:0] smp1, output logic [1:0] smp2);
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); smp1 = {addr, step, done, valid};
        @(negedge clk); smp2 = {step, done};
        @(negedge clk); tick_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({addr, step, done, valid} !== {4'd2, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", {addr, step, done, valid}, {4'd2, 3'b000});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_oneshot();
        logic [6:0] s1;
        logic [1:0] s2;
        logic [6:0] exp1 [4];
        exp1 = '{{4'd3, 3'b101}, {4'd4, 3'b101}, {4'd5, 3'b101}, {4'd5, 3'b010}};
        loop_en = 1'b0;
        pulse_start();
        checks++;
        if ({addr, step, done, valid} !== {4'd2, 3'b001}) begin
            errors++;
            $display("FAIL start_state: got %h want %h", {addr, step, done, valid}, {4'd2, 3'b001});
        end
        for (int i = 0; i < 4; i++) begin
            tick_period(s1, s2);
            checks++;
            if (s1 !== exp1[i]) begin
                errors++;
                $display("FAIL oneshot_edge%0d: got %h want %h", i, s1, exp1[i]);
            end
            checks++;
            if (s2 !== 2'b00) begin
                errors++;
                $display("FAIL oneshot_pulse_width%0d: got %b want 00", i, s2);
            end
        end
        tick_period(s1, s2);
        checks++;
        if (s1 !== {4'd5, 3'b000}) begin
            errors++;
            $display("FAIL idle_edge_ignored: got %h want %h", s1, {4'd5, 3'b000});
        end
    endtask

    task automatic test_loop();
        logic [6:0] s1;
        logic [1:0] s2;
        logic [3:0] exp_a [6];
        exp_a = '{4'd3, 4'd4, 4'd5, 4'd2, 4'd3, 4'd4};
        loop_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            tick_period(s1, s2);
            checks++;
            if (s1 !== {exp_a[i], 3'b101} || s2 !== 2'b00) begin
                errors++;
                $display("FAIL loop_edge%0d: got %h/%b want %h/00", i, s1, s2, {exp_a[i], 3'b101});
            end
        end
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        loop_en = 1'b0;
    endtask

    task automatic test_pause();
        logic [6:0] s1;
        logic [1:0] s2;
        pulse_start();
        tick_period(s1, s2);
        checks++;
        if (s1 !== {4'd3, 3'b101}) begin
            errors++;
            $display("FAIL pause_setup: got %h want %h", s1, {4'd3, 3'b101});
        end
        @(negedge clk); pause = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick_period(s1, s2);
            checks++;
            if (s1 !== {4'd3, 3'b001} || s2 !== 2'b00) begin
                errors++;
                $display("FAIL pause_hold%0d: got %h/%b want %h/00", i, s1, s2, {4'd3, 3'b001});
            end
        end
        @(negedge clk); pause = 1'b0;
        tick_period(s1, s2);
        checks++;
        if (s1 !== {4'd4, 3'b101}) begin
            errors++;
            $display("FAIL pause_resume: got %h want %h", s1, {4'd4, 3'b101});
        end
    endtask

    task automatic test_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        checks++;
        if ({addr, step, done, valid} !== {4'd2, 3'b000}) begin
            errors++;
            $display("FAIL stop_state: got %h want %h", {addr, step, done, valid}, {4'd2, 3'b000});
        end
        @(negedge clk); start = 1'b1; tick_in = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if ({addr, step, done, valid} !== {4'd2, 3'b001}) begin
            errors++;
            $display("FAIL start_with_edge: got %h want %h", {addr, step, done, valid}, {4'd2, 3'b001});
        end
        @(negedge clk);
        checks++;
        if ({addr, step} !== {4'd2, 1'b0}) begin
            errors++;
            $display("FAIL start_edge_discarded: got %h want %h", {addr, step}, {4'd2, 1'b0});
        end
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_long_high();
        int nsteps = 0;
        @(negedge clk); tick_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (step === 1'b1) nsteps++;
        end
        checks++;
        if (nsteps !== 1 || addr !== 4'd3) begin
            errors++;
            $display("FAIL long_high_one_step: got steps=%0d addr=%0d want steps=1 addr=3", nsteps, addr);
        end
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [6:0] s1;
        logic [1:0] s2;
        @(negedge clk); tick_in = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({addr, step, done, valid} !== {4'd4, 3'b101}) begin
            errors++;
            $display("FAIL pre_reset_state: got %h want %h", {addr, step, done, valid}, {4'd4, 3'b101});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({addr, step, done, valid} !== {4'd2, 3'b000}) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", {addr, step, done, valid}, {4'd2, 3'b000});
        end
        @(negedge clk); rst = 1'b0; tick_in = 1'b0;
        repeat (2) @(negedge clk);
        tick_period(s1, s2);
        checks++;
        if (s1 !== {4'd2, 3'b000} || s2 !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_no_step: got %h/%b want %h/00", s1, s2, {4'd2, 3'b000});
        end
    endtask

`ifdef ADDR_SEQ_BOUNCE_EN
    task automatic test_bounce();
        logic [6:0] s1;
        logic [1:0] s2;
        logic [6:0] exp1 [7];
        exp1 = '{{4'd3, 3'b101}, {4'd4, 3'b101}, {4'd5, 3'b101}, {4'd4, 3'b101},
                 {4'd3, 3'b101}, {4'd2, 3'b101}, {4'd2, 3'b010}};
        bounce_en = 1'b1;
        loop_en   = 1'b0;
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            tick_period(s1, s2);
            checks++;
            if (s1 !== exp1[i] || s2 !== 2'b00) begin
                errors++;
                $display("FAIL bounce_edge%0d: got %h/%b want %h/00", i, s1, s2, exp1[i]);
            end
        end
        bounce_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_oneshot();
        test_loop();
        test_pause();
        test_stop();
        test_long_high();
        test_reset_mid();
`ifdef ADDR_SEQ_BOUNCE_EN
        test_bounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_addr_seq.md
# rom_addr_seq

Address sequencer that consumes the slow square-wave output of the clock divider and steps a ROM read address once per divided-clock rising edge. It sits directly downstream of the divider and upstream of the playback ROM. It provides start/stop/pause control, one-shot or looping playback, and a `done` pulse. The whole block runs in the fast `clk` domain and treats `tick_in` as a synchronous level.

## Interface
- `ADDR_W`, default 8: address width.
- `ADDR_MIN`, default 0: first address of the playback window.
- `ADDR_MAX`, default 255: last address of the window. Must satisfy `ADDR_MIN < ADDR_MAX <= 2^ADDR_W-1`.

- `clk` in 1: system clock, rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `tick_in` in 1: divided-clock level from the divider, synchronous to `clk`.
- `start` in 1: 1-cycle pulse; begin or restart playback.
- `stop` in 1: 1-cycle pulse; abort playback.
- `pause` in 1: level; while high, ticks are ignored.
- `loop_en` in 1: level; 1 = wrap at end, 0 = one-shot.
- `addr` out ADDR_W: current ROM address (registered).
- `valid` out 1: high in RUN and PAUSE.
- `step` out 1: 1-cycle pulse on every `addr` update caused by a tick.
- `done` out 1: 1-cycle pulse at one-shot completion.

## Operation
- Edge detect: `tick_d` holds `tick_in` delayed by one cycle. `edge = tick_in & ~tick_d`. `tick_d` updates every cycle in all states.
- Reset values: state=IDLE, `addr`=ADDR_MIN, `valid`=0, `step`=0, `done`=0, `tick_d`=0, direction=up.
- States:
  - IDLE: `valid`=0.
  - RUN: `valid`=1; ticks are counted.
  - PAUSE: `valid`=1; `addr` is frozen.
- Per-cycle priority: `stop` > `start` > `pause` > `edge`.
- `stop` (any state): go to IDLE, `addr`<=ADDR_MIN, direction=up. No `done`.
- `start` (any state): go to RUN, `addr`<=ADDR_MIN, direction=up. A coincident edge is discarded, and `step` is 0 that cycle.
- RUN with `pause`=1: go to PAUSE. PAUSE with `pause`=0: go to RUN. Edges arriving in PAUSE are dropped, not queued.
- RUN with `edge`, and `addr`≠ADDR_MAX: `addr`<=`addr`+1, `step`<=1.
- RUN with `edge`, and `addr`=ADDR_MAX:
  - `loop_en`=1: `addr`<=ADDR_MIN, `step`<=1.
  - `loop_en`=0: go to IDLE, `addr` holds ADDR_MAX, `valid`<=0, `done`<=1, `step`<=0.
- Arithmetic: `addr` never leaves [ADDR_MIN, ADDR_MAX]. There is no modulo-2^ADDR_W wrap.
- `loop_en` is sampled only on the end-of-window edge.
- Mid-operation reset: all registers return to their reset values immediately.

## Timing
- `tick_in` rising at clock edge k: `addr`, `step` and `done` update at edge k+1. Latency is 1 clk.
- `start` sampled at edge k: `valid`=1 and `addr`=ADDR_MIN from edge k.
- The first `step` occurs on the first detected edge after `start`.
- `step` and `done` are registered and never asserted together.
- A divider with half-period N produces one edge every 2N clk cycles. `tick_in` held high for many cycles yields exactly one step.

## Configuration
- Macro `ADDR_SEQ_BOUNCE_EN`.
- Defined: adds input port `bounce_en` (1 bit, level).
  - With `bounce_en`=1, reaching ADDR_MAX on an edge flips the direction to down, and `addr`<=ADDR_MAX-1 with `step`.
  - Moving down, `addr` decrements.
  - At ADDR_MIN on an edge: if `loop_en`=1, the direction flips to up and `addr`<=ADDR_MIN+1 with `step`. If `loop_en`=0, the one-shot ends: IDLE, `done`, `addr` holds ADDR_MIN.
  - With `bounce_en`=0, behaviour is identical to the macro-undefined case.
- Undefined: no `bounce_en` port; the direction is always up.

## Test plan
All scenarios use ADDR_W=4, ADDR_MIN=2, ADDR_MAX=5, and `tick_in` toggling every 3 clk (one edge every 6 clk).
- Reset then `start`, `loop_en`=0:
  - `addr` goes 2→3→4→5, each step 1 clk after a `tick_in` rise.
  - On the 4th edge: `done`=1 for 1 cycle, `valid`=0, `addr`=5, no `step`.
- `loop_en`=1: the address sequence is 2,3,4,5,2,3… with `step` on every edge, and `done` never asserts.
- `pause`=1 across 2 edges at `addr`=3:
  - `addr` stays 3 and `step`=0 throughout.
  - After release, the next edge gives 4.
- `stop` at `addr`=4: next cycle `addr`=2, `valid`=0, `done`=0. `start` coincident with an edge: `addr`=2, `step`=0.
- Assert `rst` mid-run at `addr`=4: outputs are immediately 2/0/0/0, and a following edge produces no step.
- With `ADDR_SEQ_BOUNCE_EN`, `bounce_en`=1, `loop_en`=0: the sequence is 2,3,4,5,4,3,2, then `done`.
